// File: rtl/hexkey_capture.sv
// hexkey_capture: debounces hex keypad presses/releases and shifts accepted digits into a 4-digit display register.
// Latency: new_key pulses DEBOUNCE_CYCLES+1 edges after the first key_valid of a clean press; all outputs registered.
// Backpressure: none; the keypad scan stream is consumed every cycle and accepted keys are never stalled.
//
// Ports:
//   clk          scan clock (10 MHz domain)
//   rst          synchronous reset, active-high
//   key_valid    encoder found a pressed key in the current scan phase
//   key_code     encoder code {D,C,B,A}, meaningful only with key_valid
//   digits       captured digits, newest in [3:0], oldest in [15:12]
//   digit_count  digits captured since reset/clear, saturates at 4
//   last_key     most recently accepted code
//   new_key      one-cycle pulse per accepted key
//
// Optional feature macro: HEXKEY_CLEAR_KEY_EN
//   defined   -> an accepted 4'hF clears digits/digit_count instead of shifting
//   undefined -> 4'hF is an ordinary digit

module hexkey_capture #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17,
  parameter int SCAN_PERIOD     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [15:0] digits,
  output logic [2:0]  digit_count,
  output logic [3:0]  last_key,
  output logic        new_key
);

  // Hold counter must be able to store SCAN_PERIOD-1.
  localparam int HOLD_W = (SCAN_PERIOD > 2) ? $clog2(SCAN_PERIOD) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SCAN_PERIOD - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PRESS_DEB   = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [3:0]          cur_q, cur_d;
  logic [3:0]          cand_q, cand_d;
  logic [15:0]         digits_q, digits_d;
  logic [2:0]          count_q, count_d;
  logic [3:0]          last_q, last_d;
  logic                new_key_q, new_key_d;

  // Presence and the code seen this cycle. The hold window bridges the
  // scan phases in which the encoder does not report the pressed key.
  logic       present;
  logic [3:0] code_now;
  logic       accept;
  logic       clear_hit;

  assign present  = key_valid | (hold_q != '0);
  assign code_now = key_valid ? key_code : cur_q;

`ifdef HEXKEY_CLEAR_KEY_EN
  assign clear_hit = (cand_q == 4'hF);
`else
  assign clear_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    cur_d     = cur_q;
    cand_d    = cand_q;
    digits_d  = digits_q;
    count_d   = count_q;
    last_d    = last_q;
    new_key_d = 1'b0;
    accept    = 1'b0;

    // Presence tracker runs independently of the FSM, so a key_valid that
    // coincides with an accept only refreshes cur/hold.
    if (key_valid) begin
      hold_d = HOLD_LOAD;
      cur_d  = key_code;
    end else if (hold_q != '0) begin
      hold_d = hold_q - 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (present) begin
          cand_d  = code_now;
          cnt_d   = '0;
          state_d = PRESS_DEB;
        end
      end

      PRESS_DEB: begin
        if (!present) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (code_now != cand_q) begin
          // A different key restarts the debounce window for that key.
          cand_d = code_now;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      HELD: begin
        // Code changes while held are ignored; only a release matters.
        if (!present) begin
          cnt_d   = '0;
          state_d = RELEASE_DEB;
        end
      end

      RELEASE_DEB: begin
        if (present) begin
          // Bounce on release: back to HELD without a new accept.
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Accepted key: update the display register from the debounced cand.
    if (accept) begin
      new_key_d = 1'b1;
      last_d    = cand_q;
      if (clear_hit) begin
        digits_d = 16'h0000;
        count_d  = 3'd0;
      end else begin
        // Shifting past four digits drops the oldest one.
        digits_d = {digits_q[11:0], cand_q};
        if (count_q != 3'd4) begin
          count_d = count_q + 3'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      cur_q     <= 4'h0;
      cand_q    <= 4'h0;
      digits_q  <= 16'h0000;
      count_q   <= 3'd0;
      last_q    <= 4'h0;
      new_key_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      cur_q     <= cur_d;
      cand_q    <= cand_d;
      digits_q  <= digits_d;
      count_q   <= count_d;
      last_q    <= last_d;
      new_key_q <= new_key_d;
    end
  end

  assign digits      = digits_q;
  assign digit_count = count_q;
  assign last_key    = last_q;
  assign new_key     = new_key_q;

endmodule

// File: doc/hexkey_capture.md
# hexkey_capture

Debounce-and-capture stage downstream of the hexadecimal keypad scanner/encoder. Takes the 4-bit key code (D,C,B,A) and a per-scan-phase "key seen" strobe, and decides when a key has really been pressed or released. Shifts each accepted digit into a 4-digit (16-bit) display register that drives `LED[15:0]` in the keypad top level. Runs on the same 10 MHz scan clock as the 2-bit column counter.

## Interface
- `DEBOUNCE_CYCLES`, default 100000: cycles of stable press/release required (10 ms at 10 MHz); must be ≥ 2 and < 2**`CNT_W`.
- `CNT_W`, default 17: debounce counter width.
- `SCAN_PERIOD`, default 4: scan cycle length in clocks; presence hold window.
- `clk` input 1: scan clock (10 MHz domain).
- `rst` input 1: synchronous reset, active-high.
- `key_valid` input 1: encoder found a pressed key in the current scan phase.
- `key_code` input 4: encoder output {D,C,B,A}; meaningful only when `key_valid`=1.
- `digits` output 16: captured digits; newest in [3:0], oldest in [15:12].
- `digit_count` output 3: digits captured since reset/clear, saturates at 4.
- `last_key` output 4: most recently accepted code.
- `new_key` output 1: one-cycle pulse per accepted key.

## Operation
- Presence tracker: `hold` counter loads `SCAN_PERIOD-1` on `key_valid`=1, else decrements to 0. Presence `p` = `key_valid` | (`hold`≠0). Code register `cur` loads `key_code` whenever `key_valid`=1. This bridges gaps between scan phases.
- FSM states: IDLE, PRESS_DEB, HELD, RELEASE_DEB. Debounce counter `cnt` is `CNT_W` bits wide and clears on every state change.
- IDLE: if `p`, latch `cand`←current code (`key_code` if `key_valid`, else `cur`) and go to PRESS_DEB.
- PRESS_DEB:
  - `p`=0 → IDLE.
  - `p`=1 with code≠`cand` → `cand`←code, `cnt`←0, stay.
  - Otherwise `cnt`++. When `cnt`==`DEBOUNCE_CYCLES-1` at a clock edge with `p`=1 and code==`cand`: accept and go to HELD.
- Accept, same edge: `digits`←{`digits[11:0]`,`cand`}; `last_key`←`cand`; `digit_count`←min(`digit_count`+1,4); `new_key`←1 for exactly one cycle.
- HELD: `p`=0 → RELEASE_DEB. Code changes while held are ignored; a second key needs release first.
- RELEASE_DEB:
  - `p`=1 → HELD, with no new accept (bounce on release).
  - `p`=0 → `cnt`++. When `cnt`==`DEBOUNCE_CYCLES-1` → IDLE.
- With 4 digits stored, a 5th accept still shifts: the oldest digit is dropped and `digit_count` stays 4.
- Simultaneous `key_valid` and an accept edge: the accept uses `cand`. The new `key_code` only updates `cur`/`hold`.

## Timing
- Reset, synchronous, takes effect at the first edge with `rst`=1: `digits`=16'h0000, `digit_count`=0, `last_key`=4'h0, `new_key`=0, `hold`=0, `cnt`=0, state IDLE.
- Reset mid-debounce or mid-hold aborts with no accept. The key must then be released and pressed again, since post-reset IDLE sees `p` only after a new `key_valid`.
- Press latency: `new_key` is high in the cycle starting `DEBOUNCE_CYCLES`+1 edges after the first `key_valid` edge of a clean press. That is 1 edge IDLE→PRESS_DEB plus `DEBOUNCE_CYCLES` counted edges.
- Release detection: `p` falls `SCAN_PERIOD` cycles after the last `key_valid`. IDLE is reached `DEBOUNCE_CYCLES` edges after that.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `HEXKEY_CLEAR_KEY_EN` defined: an accepted code 4'hF does not shift. Instead it sets `digits`←0 and `digit_count`←0, sets `last_key`←4'hF, and still pulses `new_key`.
- `HEXKEY_CLEAR_KEY_EN` undefined: 4'hF is an ordinary digit and is shifted in like any other.

## Test plan
- Clean press (`DEBOUNCE_CYCLES`=8, `SCAN_PERIOD`=4): code 4'h5 with `key_valid` every 4th cycle for 40 cycles, then released → one `new_key` pulse, 9 edges after the first `key_valid`; `digits`=16'h0005, `digit_count`=1, `last_key`=5.
- Bouncing press: 4'h3 present 3 cycles, absent 6 cycles, then stable → accept only after the stable stretch completes 8 counted cycles; exactly one pulse.
- Code change during debounce: 4'h2 for 5 cycles, then 4'h7 stable → accepted key is 7; `digits` low nibble = 4'h7.
- Five keys 1,2,3,4,5, each with full press and release → `digits`=16'h2345, `digit_count`=4, five `new_key` pulses. Release bounce (1-cycle blip inside RELEASE_DEB) produces no extra pulse.
- Reset mid-press: `rst` asserted at `cnt`=5 in PRESS_DEB → all outputs 0 the next cycle, no `new_key`. Holding the key after reset without a new `key_valid` gives no accept.
- With `HEXKEY_CLEAR_KEY_EN`: after digits A,B, press F → `digits`=16'h0000, `digit_count`=0, `last_key`=F, one `new_key`. Without the macro: `digits`=16'h0ABF.
